// File: rtl/gps_trip_accum.sv
// Trip accumulator: sums GPS segment distances over a fixed window, tracks the
// longest segment and over-threshold count, and offers a report on valid/ready.
module gps_trip_accum #(
  parameter int SEG_PER_RPT = 8,
  parameter int CNT_W       = 8,
  parameter int TOT_W       = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             D_VALID,
  input  logic [39:0]      D_IN,
  input  logic [39:0]      THRESH,
  input  logic             CLR,
  input  logic             RPT_READY,
  output logic             RPT_VALID,
  output logic [TOT_W-1:0] RPT_TOTAL,
  output logic [39:0]      RPT_MAX,
  output logic [CNT_W-1:0] RPT_OVER,
  output logic             RPT_SAT,
  output logic             DROP,
  output logic             dbg_state_o
);

  // Report channel: RPT_* are held while RPT_VALID & ~RPT_READY; a transfer
  // happens on any edge with RPT_VALID & RPT_READY.
  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] seg_q, seg_d;
  logic [TOT_W-1:0] tot_q, tot_d;
  logic [39:0]      max_q, max_d;
  logic [CNT_W-1:0] over_q, over_d;
  logic             sat_q, sat_d;
  logic             rpt_valid_q, rpt_valid_d;
  logic [TOT_W-1:0] rpt_total_q, rpt_total_d;
  logic [39:0]      rpt_max_q, rpt_max_d;
  logic [CNT_W-1:0] rpt_over_q, rpt_over_d;
  logic             rpt_sat_q, rpt_sat_d;
  logic             drop_q, drop_d;

  logic [TOT_W:0]   sum;
  logic [CNT_W-1:0] seg_inc;
  logic [TOT_W-1:0] tot_upd;
  logic [39:0]      max_upd;
  logic [CNT_W-1:0] over_upd;
  logic             sat_upd;
  logic             accept, close, load;

  always_comb begin
    sum      = {1'b0, tot_q} + (TOT_W+1)'(D_IN);
    accept   = D_VALID & ~CLR;
    seg_inc  = seg_q + 1'b1;
    close    = accept && (seg_inc == CNT_W'(SEG_PER_RPT));
    load     = close && (!rpt_valid_q || RPT_READY);
    tot_upd  = sum[TOT_W] ? '1 : sum[TOT_W-1:0];
    sat_upd  = sat_q | sum[TOT_W];
    max_upd  = (D_IN > max_q) ? D_IN : max_q;
    over_upd = over_q + CNT_W'(D_IN > THRESH);

    state_d     = state_q;
    seg_d       = seg_q;
    tot_d       = tot_q;
    max_d       = max_q;
    over_d      = over_q;
    sat_d       = sat_q;
    rpt_valid_d = rpt_valid_q;
    rpt_total_d = rpt_total_q;
    rpt_max_d   = rpt_max_q;
    rpt_over_d  = rpt_over_q;
    rpt_sat_d   = rpt_sat_q;
    drop_d      = drop_q;

    if (CLR || close) begin
      state_d = IDLE;
      seg_d   = '0;
      tot_d   = '0;
      max_d   = '0;
      over_d  = '0;
      sat_d   = 1'b0;
      if (CLR) begin
        drop_d = 1'b0;
      end else if (!load) begin
        drop_d = 1'b1;
      end
    end else if (accept) begin
      state_d = ACCUM;
      seg_d   = seg_inc;
      tot_d   = tot_upd;
      max_d   = max_upd;
      over_d  = over_upd;
      sat_d   = sat_upd;
    end

    // A snapshot landing on a transfer edge keeps RPT_VALID high.
    if (load) begin
      rpt_valid_d = 1'b1;
      rpt_total_d = tot_upd;
      rpt_max_d   = max_upd;
      rpt_over_d  = over_upd;
      rpt_sat_d   = sat_upd;
    end else if (rpt_valid_q && RPT_READY) begin
      rpt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      seg_q       <= '0;
      tot_q       <= '0;
      max_q       <= '0;
      over_q      <= '0;
      sat_q       <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_total_q <= '0;
      rpt_max_q   <= '0;
      rpt_over_q  <= '0;
      rpt_sat_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      tot_q       <= tot_d;
      max_q       <= max_d;
      over_q      <= over_d;
      sat_q       <= sat_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_total_q <= rpt_total_d;
      rpt_max_q   <= rpt_max_d;
      rpt_over_q  <= rpt_over_d;
      rpt_sat_q   <= rpt_sat_d;
      drop_q      <= drop_d;
    end
  end

  assign RPT_VALID   = rpt_valid_q;
  assign RPT_TOTAL   = rpt_total_q;
  assign RPT_MAX     = rpt_max_q;
  assign RPT_OVER    = rpt_over_q;
  assign RPT_SAT     = rpt_sat_q;
  assign DROP        = drop_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gps_trip_accum.sv
// Bench for gps_trip_accum: a 4-segment/48-bit instance checked every cycle
// against a window-of-samples model, plus a 2-segment/40-bit saturation instance.
module tb_gps_trip_accum;

  localparam logic [39:0] ONE = 40'h01_0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        check_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Instance A: SEG_PER_RPT=4, TOT_W=48
  logic        a_dv = 1'b0, a_clr = 1'b0, a_rdy = 1'b0;
  logic [39:0] a_d = '0;
  logic [39:0] a_thr = ONE;
  logic        a_valid, a_sat, a_drop, a_state;
  logic [47:0] a_total;
  logic [39:0] a_max;
  logic [7:0]  a_over;

  // Instance B: SEG_PER_RPT=2, TOT_W=40
  logic        b_dv = 1'b0, b_rdy = 1'b1;
  logic [39:0] b_d = '0;
  logic [39:0] b_thr = ONE;
  logic        b_valid, b_sat, b_drop, b_state;
  logic [39:0] b_total;
  logic [39:0] b_max;
  logic [7:0]  b_over;

  always #5 clk = ~clk;

  gps_trip_accum #(.SEG_PER_RPT(4), .CNT_W(8), .TOT_W(48)) dut_a (
    .clk(clk), .reset(reset), .D_VALID(a_dv), .D_IN(a_d), .THRESH(a_thr),
    .CLR(a_clr), .RPT_READY(a_rdy), .RPT_VALID(a_valid), .RPT_TOTAL(a_total),
    .RPT_MAX(a_max), .RPT_OVER(a_over), .RPT_SAT(a_sat), .DROP(a_drop),
    .dbg_state_o(a_state)
  );

  gps_trip_accum #(.SEG_PER_RPT(2), .CNT_W(8), .TOT_W(40)) dut_b (
    .clk(clk), .reset(reset), .D_VALID(b_dv), .D_IN(b_d), .THRESH(b_thr),
    .CLR(1'b0), .RPT_READY(b_rdy), .RPT_VALID(b_valid), .RPT_TOTAL(b_total),
    .RPT_MAX(b_max), .RPT_OVER(b_over), .RPT_SAT(b_sat), .DROP(b_drop),
    .dbg_state_o(b_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: collect the samples of the open window; a report is derived from
  // the whole window at the fourth sample.
  logic [39:0] m_win [3];
  int          m_n;
  logic        m_valid, m_sat, m_drop;
  logic [47:0] m_total;
  logic [39:0] m_max;
  logic [7:0]  m_over;

  always @(posedge clk or posedge reset) begin : model
    longint unsigned s;
    logic [39:0]     mx;
    logic [39:0]     smp;
    int              ov;
    if (reset) begin
      m_n <= 0; m_valid <= 0; m_sat <= 0; m_drop <= 0;
      m_total <= '0; m_max <= '0; m_over <= '0;
    end else if (a_clr) begin
      m_n    <= 0;
      m_drop <= 0;
      if (m_valid && a_rdy) m_valid <= 0;
    end else if (a_dv && m_n == 3) begin
      s  = 64'(a_d);
      mx = a_d;
      ov = (a_d > a_thr) ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
        smp = m_win[i];
        s  += 64'(smp);
        if (smp > mx) mx = smp;
        if (smp > a_thr) ov++;
      end
      m_n <= 0;
      if (!m_valid || a_rdy) begin
        m_valid <= 1;
        m_sat   <= (s > 64'h0000_FFFF_FFFF_FFFF);
        m_total <= (s > 64'h0000_FFFF_FFFF_FFFF) ? 48'hFFFF_FFFF_FFFF : s[47:0];
        m_max   <= mx;
        m_over  <= ov[7:0];
      end else begin
        m_drop <= 1;
      end
    end else begin
      if (a_dv) begin
        m_win[m_n] <= a_d;
        m_n        <= m_n + 1;
      end
      if (m_valid && a_rdy) m_valid <= 0;
    end
  end

  always @(negedge clk) begin
    if (check_en && !reset) begin
      chk("a_valid", 64'(a_valid), 64'(m_valid));
      chk("a_drop", 64'(a_drop), 64'(m_drop));
      chk("a_state", 64'(a_state), 64'(m_n != 0));
      if (m_valid) begin
        chk("a_total", 64'(a_total), 64'(m_total));
        chk("a_max", 64'(a_max), 64'(m_max));
        chk("a_over", 64'(a_over), 64'(m_over));
        chk("a_sat", 64'(a_sat), 64'(m_sat));
      end
    end
  end

  task automatic step(input logic dv, input logic [39:0] d, input logic c, input logic r);
    @(negedge clk);
    a_dv = dv; a_d = d; a_clr = c; a_rdy = r;
  endtask

  task automatic bstep(input logic dv, input logic [39:0] d);
    @(negedge clk);
    b_dv = dv; b_d = d;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a_valid"}, 64'(a_valid), 64'd0);
    chk({tag, "_a_total"}, 64'(a_total), 64'd0);
    chk({tag, "_a_max"}, 64'(a_max), 64'd0);
    chk({tag, "_a_over"}, 64'(a_over), 64'd0);
    chk({tag, "_a_sat"}, 64'(a_sat), 64'd0);
    chk({tag, "_a_drop"}, 64'(a_drop), 64'd0);
    chk({tag, "_b_valid"}, 64'(b_valid), 64'd0);
    chk({tag, "_b_total"}, 64'(b_total), 64'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    check_all_zero("rst");
    reset = 1'b0;
    check_en = 1'b1;

    // Basic window with mixed over/not-over samples
    step(1, 40'h00_8000_0000, 0, 1);
    step(1, 40'h02_0000_0000, 0, 1);
    step(1, 40'h01_0000_0000, 0, 1);
    step(1, 40'h03_4000_0000, 0, 1);
    step(0, '0, 0, 1);
    chk("t1_valid", 64'(a_valid), 64'd1);
    chk("t1_total", 64'(a_total), 64'h0006_C000_0000);
    chk("t1_max", 64'(a_max), 64'h03_4000_0000);
    chk("t1_over", 64'(a_over), 64'd2);
    chk("t1_sat", 64'(a_sat), 64'd0);

    // Consumer stalled across two windows: second report dropped
    for (int i = 0; i < 4; i++) step(1, ONE, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 40'h02_0000_0000, 0, 0);
    step(0, '0, 0, 0);
    chk("t2_valid", 64'(a_valid), 64'd1);
    chk("t2_total", 64'(a_total), 64'h0004_0000_0000);
    chk("t2_max", 64'(a_max), 64'(ONE));
    chk("t2_drop", 64'(a_drop), 64'd1);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);
    chk("t2_valid_after_ready", 64'(a_valid), 64'd0);

    // CLR with a concurrent sample discards the open window and clears DROP
    step(1, 40'h03_0000_0000, 0, 0);
    step(1, 40'h03_0000_0000, 0, 0);
    step(1, 40'h05_0000_0000, 1, 0);
    for (int i = 0; i < 4; i++) step(1, ONE, 0, 0);
    step(0, '0, 0, 0);
    chk("t5_valid", 64'(a_valid), 64'd1);
    chk("t5_total", 64'(a_total), 64'h0004_0000_0000);
    chk("t5_max", 64'(a_max), 64'(ONE));
    chk("t5_over", 64'(a_over), 64'd0);
    chk("t5_drop", 64'(a_drop), 64'd0);
    step(0, '0, 0, 1);

    // Ready arrives in exactly the closing cycle: new report replaces old
    step(1, 40'h01_0000_0000, 0, 0);
    step(1, 40'h02_0000_0000, 0, 0);
    step(1, 40'h03_0000_0000, 0, 0);
    step(1, 40'h04_0000_0000, 0, 0);
    step(0, '0, 0, 0);
    chk("t3_first_total", 64'(a_total), 64'h000A_0000_0000);
    chk("t3_first_over", 64'(a_over), 64'd3);
    for (int i = 0; i < 3; i++) step(1, 40'h00_8000_0000, 0, 0);
    step(1, 40'h00_8000_0000, 0, 1);
    step(0, '0, 0, 0);
    chk("t3_valid", 64'(a_valid), 64'd1);
    chk("t3_total", 64'(a_total), 64'h0002_0000_0000);
    chk("t3_max", 64'(a_max), 64'h00_8000_0000);
    chk("t3_drop", 64'(a_drop), 64'd0);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);

    // Saturation on the 40-bit instance, then a clean window
    bstep(1, 40'hFF_FFFF_FFFF);
    bstep(1, 40'hFF_FFFF_FFFF);
    bstep(0, '0);
    chk("b_sat_valid", 64'(b_valid), 64'd1);
    chk("b_sat_total", 64'(b_total), 64'hFF_FFFF_FFFF);
    chk("b_sat_flag", 64'(b_sat), 64'd1);
    chk("b_sat_over", 64'(b_over), 64'd2);
    bstep(1, ONE);
    bstep(1, ONE);
    bstep(0, '0);
    chk("b_next_total", 64'(b_total), 64'h02_0000_0000);
    chk("b_next_sat", 64'(b_sat), 64'd0);
    chk("b_next_max", 64'(b_max), 64'(ONE));
    chk("b_next_over", 64'(b_over), 64'd0);

    // Asynchronous reset with a pending report and a half-filled window
    for (int i = 0; i < 4; i++) step(1, ONE, 0, 0);
    step(1, ONE, 0, 0);
    step(1, ONE, 0, 0);
    step(0, '0, 0, 0);
    chk("t6_pending", 64'(a_valid), 64'd1);
    #2 reset = 1'b1;
    #1 check_all_zero("async");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 40'h00_4000_0000, 0, 1);
    step(0, '0, 0, 0);
    chk("t6_valid", 64'(a_valid), 64'd1);
    chk("t6_total", 64'(a_total), 64'h0001_0000_0000);
    chk("t6_max", 64'(a_max), 64'h00_4000_0000);
    chk("t6_over", 64'(a_over), 64'd0);
    chk("t6_drop", 64'(a_drop), 64'd0);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
